// File: rtl/seven_tube_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seven_tube_pkg
//  Purpose  : Shared definitions for the multiplexed seven-segment driver:
//             hex-to-segment table, dark pattern and select-width helper.
//  Revision : 1.0  initial release
// ============================================================================
package seven_tube_pkg;

   // Active-high pattern with every segment (and dp) dark.
   localparam logic [7:0] SEG_OFF = 8'h00;

   // Hex nibble to active-high {g,f,e,d,c,b,a}.
   function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
      logic [6:0] pat;
      case (nibble)
         4'h0: pat = 7'h3F;
         4'h1: pat = 7'h06;
         4'h2: pat = 7'h5B;
         4'h3: pat = 7'h4F;
         4'h4: pat = 7'h66;
         4'h5: pat = 7'h6D;
         4'h6: pat = 7'h7D;
         4'h7: pat = 7'h07;
         4'h8: pat = 7'h7F;
         4'h9: pat = 7'h6F;
         4'hA: pat = 7'h77;
         4'hB: pat = 7'h7C;
         4'hC: pat = 7'h39;
         4'hD: pat = 7'h5E;
         4'hE: pat = 7'h79;
         default: pat = 7'h71;
      endcase
      return pat;
   endfunction

   // Width needed to index 'count' items; never narrower than one bit.
   function automatic int sel_width(input int count);
      return (count <= 1) ? 1 : $clog2(count);
   endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_decode.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_decode
//  Purpose  : Combinational nibble + dp to active-high {dp,g..a} pattern.
//             'blank' darkens a..g only; dp passes through untouched.
//  Revision : 1.0  initial release
// ============================================================================
module seven_seg_decode
   import seven_tube_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       dp,
   input  logic       blank,
   output logic [7:0] pattern
);

   // Build the lit pattern; leading-zero blanking keeps the decimal point.
   always_comb begin
      pattern    = SEG_OFF;
      pattern[7] = dp;
      if (!blank) begin
         pattern[6:0] = seg_decode(nibble);
      end
   end

endmodule
`default_nettype wire

// File: rtl/seven_tube_scan.sv
`default_nettype none
// ============================================================================
//  Module   : seven_tube_scan
//  Purpose  : Multiplexed DIGITS-wide hex display driver with per-digit dp,
//             leading-zero blanking, 16-level PWM and tear-free staged loads.
//             Optional digit blinking when SEVEN_TUBE_BLINK_EN is defined
//             (adds blink_mask port and BLINK_HZ parameter).
//  Revision : 1.0  initial release
// ============================================================================
module seven_tube_scan
   import seven_tube_pkg::*;
#(
   parameter int DIGITS         = 6,
   parameter int CLK_FREQ       = 50_000_000,
   parameter int SCAN_HZ        = 1000,
   parameter bit SEG_ACTIVE_LOW = 1'b1
`ifdef SEVEN_TUBE_BLINK_EN
   ,
   parameter int BLINK_HZ       = 2
`endif
)(
   input  logic                          sys_clk,
   input  logic                          sys_rst,
   input  logic [4*DIGITS-1:0]           data_in,
   input  logic [DIGITS-1:0]             dp_in,
   input  logic                          data_valid,
   output logic                          data_ready,
   input  logic                          blank_lz,
   input  logic [3:0]                    bright,
`ifdef SEVEN_TUBE_BLINK_EN
   input  logic [DIGITS-1:0]             blink_mask,
`endif
   output logic [sel_width(DIGITS)-1:0]  sel,
   output logic [7:0]                    seg,
   output logic                          frame_start
);

   localparam int               DIV      = CLK_FREQ / SCAN_HZ;
   localparam int               DIV_W    = sel_width(DIV);
   localparam int               SEL_W    = sel_width(DIGITS);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(DIGITS - 1);
   localparam logic [7:0]       POL      = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

   logic [DIV_W-1:0]    div_cnt;
   logic [SEL_W-1:0]    scan_idx;
   logic [3:0]          pwm_cnt;
   logic                slot_end;
   logic                frame_wrap;

   logic [4*DIGITS-1:0] active_data;
   logic [DIGITS-1:0]   active_dp;
   logic [4*DIGITS-1:0] pending_data;
   logic [DIGITS-1:0]   pending_dp;
   logic                pending;
   logic                load_accept;

   logic [DIGITS-1:0]   zero_from;
   logic [3:0]          cur_nib;
   logic                cur_dp;
   logic                cur_zero;
   logic                lz_blank;
   logic                pwm_on;
   logic [7:0]          pattern;
   logic [7:0]          seg_next;

   assign slot_end    = (div_cnt == DIV_LAST);
   assign frame_wrap  = slot_end && (scan_idx == IDX_LAST);
   assign data_ready  = ~pending;
   assign load_accept = data_valid & ~pending;

   // Slot divider, scan index and free-running PWM phase.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         div_cnt  <= '0;
         scan_idx <= '0;
         pwm_cnt  <= 4'd0;
      end else begin
         pwm_cnt <= pwm_cnt + 4'd1;
         if (slot_end) begin
            div_cnt  <= '0;
            scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + SEL_W'(1);
         end else begin
            div_cnt  <= div_cnt + DIV_W'(1);
         end
      end
   end

   // Staging: a load waits in pending and is promoted only at a frame wrap,
   // so one frame never shows a mix of old and new digits.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         active_data  <= '0;
         active_dp    <= '0;
         pending_data <= '0;
         pending_dp   <= '0;
         pending      <= 1'b0;
      end else begin
         if (frame_wrap && pending) begin
            active_data <= pending_data;
            active_dp   <= pending_dp;
            pending     <= 1'b0;
         end
         // Only possible while nothing is pending, so never collides with
         // the promotion above; a wrap-cycle capture waits one more frame.
         if (load_accept) begin
            pending_data <= data_in;
            pending_dp   <= dp_in;
            pending      <= 1'b1;
         end
      end
   end

   // zero_from[i]: digit i and every digit above it are zero.
   always_comb begin
      zero_from = '0;
      for (int i = 0; i < DIGITS; i++) begin
         zero_from[i] = ((active_data >> (4 * i)) == '0);
      end
   end

`ifdef SEVEN_TUBE_BLINK_EN
   localparam int                 BLINK_DIV  = CLK_FREQ / (2 * BLINK_HZ);
   localparam int                 BLINK_W    = sel_width(BLINK_DIV);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

   logic [BLINK_W-1:0] blink_cnt;
   logic               blink_phase;
   logic               cur_mask;

   // Blink phase toggles every half blink period.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt   <= blink_cnt + BLINK_W'(1);
      end
   end
`endif

   // Pick the nibble, dp and blanking facts of the digit being scanned.
   always_comb begin
      cur_nib  = 4'h0;
      cur_dp   = 1'b0;
      cur_zero = 1'b0;
`ifdef SEVEN_TUBE_BLINK_EN
      cur_mask = 1'b0;
`endif
      for (int i = 0; i < DIGITS; i++) begin
         if (scan_idx == SEL_W'(i)) begin
            cur_nib  = active_data[4*i +: 4];
            cur_dp   = active_dp[i];
            cur_zero = zero_from[i];
`ifdef SEVEN_TUBE_BLINK_EN
            cur_mask = blink_mask[i];
`endif
         end
      end
   end

   // Digit 0 always shows, even when the whole value is zero.
   assign lz_blank = blank_lz && (scan_idx != '0) && cur_zero;
   assign pwm_on   = (bright == 4'hF) || (pwm_cnt < bright);

   seven_seg_decode u_decode (
      .nibble  (cur_nib),
      .dp      (cur_dp),
      .blank   (lz_blank),
      .pattern (pattern)
   );

   // Brightness gate and blink blanking darken all eight segments.
   always_comb begin
      seg_next = pattern;
      if (!pwm_on) begin
         seg_next = SEG_OFF;
      end
`ifdef SEVEN_TUBE_BLINK_EN
      if (blink_phase && cur_mask) begin
         seg_next = SEG_OFF;
      end
`endif
   end

   // Registered pin drivers with board polarity applied.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         sel         <= '0;
         seg         <= SEG_OFF ^ POL;
         frame_start <= 1'b0;
      end else begin
         sel         <= scan_idx;
         seg         <= seg_next ^ POL;
         frame_start <= frame_wrap;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seven_tube_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_seven_tube_scan
//  Purpose  : Self-checking bench for seven_tube_scan (DIGITS=6, DIV=16,
//             common anode). Table vectors, corner sequences and random
//             traffic against a cycle-count reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seven_tube_scan;

   localparam int DIGITS = 6;
   localparam int DIV    = 16;
   localparam int FRAME  = DIV * DIGITS;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [23:0] data_in = '0;
   logic [5:0]  dp_in = '0;
   logic        data_valid = 1'b0;
   logic        blank_lz = 1'b0;
   logic [3:0]  bright = 4'hF;
   logic        data_ready;
   logic [2:0]  sel;
   logic [7:0]  seg;
   logic        frame_start;

   seven_tube_scan #(
      .DIGITS         (DIGITS),
      .CLK_FREQ       (1600),
      .SCAN_HZ        (100),
      .SEG_ACTIVE_LOW (1'b1)
   ) dut (
      .sys_clk     (clk),
      .sys_rst     (rst),
      .data_in     (data_in),
      .dp_in       (dp_in),
      .data_valid  (data_valid),
      .data_ready  (data_ready),
      .blank_lz    (blank_lz),
      .bright      (bright),
`ifdef SEVEN_TUBE_BLINK_EN
      .blink_mask  (6'b000000),
`endif
      .sel         (sel),
      .seg         (seg),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   int passes = 0;
   int checks = 0;

   // Reference model: time measured in clock edges since reset release.
   int          n;
   logic [23:0] m_active, m_pend_data;
   logic [5:0]  m_dp, m_pend_dp;
   bit          m_pending;
   logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   typedef struct packed {
      logic [23:0]     data;
      logic [5:0]      dp;
      logic            blz;
      logic [5:0][7:0] exp;   // exp[k] = pin value while digit k is selected
   } vec_t;
   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, n);
   endtask

   function automatic logic [7:0] model_seg(input int d, input int pwm);
      logic [7:0] pat;
      logic [3:0] nib;
      nib = m_active[4*d +: 4];
      pat = {m_dp[d], hex_tab[nib]};
      if (blank_lz && d != 0 && (m_active >> (4 * d)) == 24'h0) pat[6:0] = 7'h00;
      if (!(bright == 4'hF || pwm < int'(bright))) pat = 8'h00;
      return ~pat;
   endfunction

   task automatic model_reset();
      n = 0; m_active = '0; m_dp = '0; m_pend_data = '0; m_pend_dp = '0; m_pending = 0;
   endtask

   // One clock: predict from pre-edge state/inputs, advance model, compare.
   task automatic tick();
      int         d, pwm;
      logic [2:0] e_sel;
      logic [7:0] e_seg;
      logic       e_fs;
      bit         cap;
      d     = (n / DIV) % DIGITS;
      pwm   = n % 16;
      e_sel = 3'(d);
      e_seg = model_seg(d, pwm);
      e_fs  = ((n + 1) % FRAME == 0);
      cap   = data_valid && !m_pending;
      if (e_fs && m_pending) begin
         m_active = m_pend_data; m_dp = m_pend_dp; m_pending = 0;
      end
      if (cap) begin
         m_pend_data = data_in; m_pend_dp = dp_in; m_pending = 1;
      end
      @(posedge clk); #1; n++;
      check("sel", 32'(sel), 32'(e_sel));
      check("seg", 32'(seg), 32'(e_seg));
      check("frame_start", 32'(frame_start), 32'(e_fs));
      check("data_ready", 32'(data_ready), 32'(!m_pending));
   endtask

   task automatic do_reset();
      rst = 1'b1; data_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("rst_sel", 32'(sel), 32'h0);
      check("rst_seg", 32'(seg), 32'hFF);
      check("rst_ready", 32'(data_ready), 32'h1);
      check("rst_frame_start", 32'(frame_start), 32'h0);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic wait_frame();
      bit ok = 0;
      for (int i = 0; i < 2 * FRAME && !ok; i++) begin
         tick();
         if (frame_start) ok = 1;
      end
      check("frame_wait_timeout", 32'(ok), 32'h1);
   endtask

   task automatic load(input logic [23:0] d, input logic [5:0] p);
      for (int i = 0; i < 2 * FRAME && !data_ready; i++) tick();
      check("ready_before_load", 32'(data_ready), 32'h1);
      data_in = d; dp_in = p; data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
   endtask

   // After a frame_start sample: one tick enters slot 0, then mid-slot of digit 0.
   task automatic to_slot0_mid();
      tick();
      repeat (8) tick();
   endtask

   task automatic count_lit(input logic [3:0] b, input int exp_lit);
      int lit = 0;
      bright = b;
      tick();
      for (int i = 0; i < 16; i++) begin
         tick();
         if (seg != 8'hFF) lit++;
      end
      check($sformatf("pwm_lit_b%0h", b), 32'(lit), 32'(exp_lit));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{24'h012345, 6'b000000, 1'b0, {8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92}};
      vecs[1] = '{24'h000070, 6'b000000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF8, 8'hC0}};
      vecs[2] = '{24'h000000, 6'b000000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0}};
      vecs[3] = '{24'hABCDEF, 6'b101010, 1'b0, {8'h08, 8'h83, 8'h46, 8'hA1, 8'h06, 8'h8E}};
      vecs[4] = '{24'h000100, 6'b100000, 1'b1, {8'h7F, 8'hFF, 8'hFF, 8'hF9, 8'hC0, 8'hC0}};
      vecs[5] = '{24'h987600, 6'b000001, 1'b1, {8'h90, 8'h80, 8'hF8, 8'h82, 8'hC0, 8'h40}};
      model_reset();

      #1;
      do_reset();

      // Table vectors: load, let it apply, check each slot mid-way.
      for (int v = 0; v < 6; v++) begin
         blank_lz = vecs[v].blz;
         bright   = 4'hF;
         load(vecs[v].data, vecs[v].dp);
         check("ready_low_after_load", 32'(data_ready), 32'h0);
         wait_frame();
         tick();
         for (int k = 0; k < DIGITS; k++) begin
            repeat (8) tick();
            check($sformatf("tbl%0d_sel%0d", v, k), 32'(sel), 32'(k));
            check($sformatf("tbl%0d_seg%0d", v, k), 32'(seg), 32'(vecs[v].exp[k]));
            repeat (8) tick();
         end
      end

      // PWM windows.
      blank_lz = 1'b0;
      load(24'h888888, 6'b000000);
      wait_frame();
      count_lit(4'h3, 3);
      count_lit(4'h0, 0);
      count_lit(4'hF, 16);
      bright = 4'hF;

      // A second valid while a load is pending is ignored.
      load(24'h111111, 6'b000000);
      data_in = 24'h222222; data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      check("ignored_ready", 32'(data_ready), 32'h0);
      wait_frame();
      to_slot0_mid();
      check("ignored_seg0", 32'(seg), 32'hF9);

      // Valid on the wrap cycle waits a full extra frame.
      for (int i = 0; i < FRAME && ((n + 1) % FRAME != 0); i++) tick();
      data_in = 24'h333333; data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      check("wrapcap_fs", 32'(frame_start), 32'h1);
      check("wrapcap_ready", 32'(data_ready), 32'h0);
      to_slot0_mid();
      check("wrapcap_old_seg0", 32'(seg), 32'hF9);
      wait_frame();
      to_slot0_mid();
      check("wrapcap_new_seg0", 32'(seg), 32'hB0);

      // Async reset mid-slot at sel=3 with a load pending.
      wait_frame();
      tick();
      load(24'h555555, 6'b111111);
      for (int i = 0; i < FRAME && sel != 3'd3; i++) tick();
      repeat (8) tick();
      check("pre_rst_sel", 32'(sel), 32'h3);
      #3 rst = 1'b1;
      #1;
      check("async_sel", 32'(sel), 32'h0);
      check("async_seg", 32'(seg), 32'hFF);
      check("async_ready", 32'(data_ready), 32'h1);
      check("async_fs", 32'(frame_start), 32'h0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      wait_frame();
      to_slot0_mid();
      check("after_rst_seg0", 32'(seg), 32'hC0);

      // Random traffic against the model.
      for (int c = 0; c < 1500; c++) begin
         if (c % 64 == 0) bright = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
         if (c % 100 == 0) blank_lz = 1'($urandom);
         data_in    = 24'($urandom) >> (4 * $urandom_range(0, 6));
         dp_in      = 6'($urandom);
         data_valid = ($urandom_range(0, 7) == 0);
         tick();
      end
      data_valid = 1'b0;

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
